// File: rtl/pll_cfg_pkg.sv
// pll_cfg_pkg: shared states, divider widths and configuration record for the PLL sequencer
package pll_cfg_pkg;
    localparam int MW = 17;
    localparam int NW = 10;
    localparam int PW = 7;
    typedef enum logic [2:0] {IDLE, PD_HOLD, WAIT_LOCK, STABLE, RUN, ERROR} state_e;
    typedef struct packed {
        logic [MW-1:0] m;
        logic [NW-1:0] n;
        logic [PW-1:0] p;
        logic          directi;
        logic          directo;
        logic          bypass;
    } cfg_t;
    localparam cfg_t CFG_RST = '{m: MW'(1), n: NW'(1), p: PW'(1), directi: 1'b0, directo: 1'b0, bypass: 1'b0};
    function automatic logic cfg_valid(input cfg_t c);
        return (|c.m) && (|c.n) && (|c.p);
    endfunction
endpackage

// File: rtl/pll_cfg_ctrl_if.sv
// pll_cfg_ctrl_if: configuration request/acknowledge handshake
interface pll_cfg_ctrl_if;
    import pll_cfg_pkg::*;
    logic req;
    cfg_t data;
    logic ack;
    logic done;
    modport master (output req, data, input ack, done);
    modport slave (input req, data, output ack, done);
endinterface

// File: rtl/pll_lock_sync.sv
// pll_lock_sync: two-flop synchronizer for the raw PLL lock, held low while force_low_i
module pll_lock_sync (
    input  logic clkin,
    input  logic rst_n,
    input  logic lock_i,
    input  logic force_low_i,
    output logic lock_s_o
);
    logic [1:0] sync_q;
    always_ff @(posedge clkin or negedge rst_n)
        if (!rst_n) sync_q <= 2'b00;
        else sync_q <= force_low_i ? 2'b00 : {sync_q[0], lock_i};
    assign lock_s_o = sync_q[1];
endmodule

// File: rtl/pll_cfg_ctrl.sv
// pll_cfg_ctrl: power-down/load/release/lock-wait sequencer driving the analog PLL controls
module pll_cfg_ctrl import pll_cfg_pkg::*; #(
    parameter int PD_CYCLES    = 4,
    parameter int LOCK_TIMEOUT = 64,
    parameter int LOCK_STABLE  = 8,
    parameter int MAX_RETRY    = 2,
    parameter bit AUTO_RELOCK  = 1'b1
) (
    input  logic          clkin,
    input  logic          rst_n,
    pll_cfg_ctrl_if.slave cfg,
    output logic          pll_pd_o,
    output logic [MW-1:0] pll_mdec_o,
    output logic [NW-1:0] pll_ndec_o,
    output logic [PW-1:0] pll_pdec_o,
    output logic          pll_mreq_o,
    output logic          pll_nreq_o,
    output logic          pll_preq_o,
    output logic          pll_directi_o,
    output logic          pll_directo_o,
    output logic          pll_bypass_o,
    output logic          pll_clken_o,
    input  logic          pll_lock_i,
    output logic          busy_o,
    output logic          locked_o,
    output logic          err_invalid_o,
    output logic          err_timeout_o,
    output logic          lock_lost_o,
    output logic [1:0]    retry_cnt_o
);
    localparam int CMAX = LOCK_TIMEOUT > PD_CYCLES ? (LOCK_TIMEOUT > LOCK_STABLE ? LOCK_TIMEOUT : LOCK_STABLE)
                                                   : (PD_CYCLES > LOCK_STABLE ? PD_CYCLES : LOCK_STABLE);
    localparam int CW = $clog2(CMAX + 1);

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    cfg_t          cfg_q, cfg_d;
    logic          pd_q, pd_d, clken_q, clken_d, req_q, req_d, ack_q, ack_d, done_q, done_d;
    logic          inv_q, inv_d, to_q, to_d, lost_q, lost_d;
    logic [1:0]    retry_q, retry_d;
    logic          lock_s, lost_now, accept;

    pll_lock_sync u_sync (
        .clkin(clkin),
        .rst_n(rst_n),
        .lock_i(pll_lock_i),
        .force_low_i(pd_q),
        .lock_s_o(lock_s)
    );

    // bypass mode runs without a lock reference, so lock loss is ignored there
    assign lost_now = state_q == RUN && !lock_s && !cfg_q.bypass;
    assign accept   = cfg.req && (state_q inside {IDLE, RUN, ERROR});

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        cfg_d   = cfg_q;
        ack_d   = 1'b0;
        done_d  = 1'b0;
        inv_d   = inv_q;
        to_d    = to_q;
        lost_d  = lost_q | lost_now;
        retry_d = retry_q;
        if (accept) begin
            ack_d   = 1'b1;
            to_d    = 1'b0;
            lost_d  = lost_now;
            retry_d = 2'd0;
            cnt_d   = '0;
            inv_d   = !cfg_valid(cfg.data);
            state_d = inv_d ? IDLE : PD_HOLD;
            cfg_d   = inv_d ? cfg_q : cfg.data;
        end else begin
            case (state_q)
                PD_HOLD: if (cnt_q == CW'(PD_CYCLES - 1)) begin
                    state_d = cfg_q.bypass ? RUN : WAIT_LOCK;
                    done_d  = cfg_q.bypass;
                    cnt_d   = '0;
                end
                WAIT_LOCK: if (lock_s) begin
                    state_d = STABLE;
                    cnt_d   = CW'(1);
                end else if (cnt_q == CW'(LOCK_TIMEOUT - 1)) begin
                    cnt_d   = '0;
                    state_d = retry_q < 2'(MAX_RETRY) ? PD_HOLD : ERROR;
                    retry_d = retry_q < 2'(MAX_RETRY) ? retry_q + 2'd1 : retry_q;
                    to_d    = retry_q >= 2'(MAX_RETRY);
                end
                STABLE: if (!lock_s) begin
                    state_d = WAIT_LOCK;
                    cnt_d   = '0;
                end else if (cnt_q == CW'(LOCK_STABLE - 1)) begin
                    state_d = RUN;
                    done_d  = 1'b1;
                end
                RUN: if (lost_now) begin
                    state_d = AUTO_RELOCK ? WAIT_LOCK : ERROR;
                    cnt_d   = '0;
                end
                default: ;
            endcase
        end
        pd_d    = state_d inside {IDLE, PD_HOLD, ERROR};
        clken_d = state_d == RUN;
        req_d   = state_d == PD_HOLD;
    end

    always_ff @(posedge clkin or negedge rst_n)
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            cfg_q   <= CFG_RST;
            pd_q    <= 1'b1;
            clken_q <= 1'b0;
            req_q   <= 1'b0;
            ack_q   <= 1'b0;
            done_q  <= 1'b0;
            inv_q   <= 1'b0;
            to_q    <= 1'b0;
            lost_q  <= 1'b0;
            retry_q <= 2'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cfg_q   <= cfg_d;
            pd_q    <= pd_d;
            clken_q <= clken_d;
            req_q   <= req_d;
            ack_q   <= ack_d;
            done_q  <= done_d;
            inv_q   <= inv_d;
            to_q    <= to_d;
            lost_q  <= lost_d;
            retry_q <= retry_d;
        end

    assign cfg.ack       = ack_q;
    assign cfg.done      = done_q;
    assign pll_pd_o      = pd_q;
    assign pll_mdec_o    = cfg_q.m;
    assign pll_ndec_o    = cfg_q.n;
    assign pll_pdec_o    = cfg_q.p;
    assign pll_mreq_o    = req_q;
    assign pll_nreq_o    = req_q;
    assign pll_preq_o    = req_q;
    assign pll_directi_o = cfg_q.directi;
    assign pll_directo_o = cfg_q.directo;
    assign pll_bypass_o  = cfg_q.bypass;
    assign pll_clken_o   = clken_q;
    assign busy_o        = state_q inside {PD_HOLD, WAIT_LOCK, STABLE};
    assign locked_o      = state_q == RUN;
    assign err_invalid_o = inv_q;
    assign err_timeout_o = to_q;
    assign lock_lost_o   = lost_q;
    assign retry_cnt_o   = retry_q;
endmodule

// File: doc/pll_cfg_ctrl.md
Name: pll_cfg_ctrl

Overview:
Sequencer directly upstream of the analog PLL macro, clocked by the PLL reference clock. Accepts divider/mode configuration requests and drives the PLL control inputs (pd, mdec/ndec/pdec, m/n/preq, directi/directo, bypass, clken). Walks the power-down / load / release / lock-wait sequence and gates clken until lock has been stable. Monitors lock in service and handles timeout retries and lock loss.

Parameters:
PD_CYCLES, 4, cycles pd held high with new dividers applied before release (min 2)
LOCK_TIMEOUT, 64, max cycles in WAIT_LOCK per attempt
LOCK_STABLE, 8, consecutive synchronized-lock cycles required before clken
MAX_RETRY, 2, relock attempts after a timeout before ERROR
AUTO_RELOCK, 1, 1: lock loss in RUN goes to WAIT_LOCK; 0: goes to ERROR

Ports:
clkin  in  1  reference clock; all logic on rising edge
rst_n  in  1  asynchronous active-low reset
cfg_req  in  1  level request; cfg_* fields valid while high
cfg_m  in  17  feedback divider value
cfg_n  in  10  pre-divider value
cfg_p  in  7  post-divider value
cfg_directi  in  1  bypass input divider
cfg_directo  in  1  bypass post divider
cfg_bypass  in  1  PLL bypass mode
cfg_ack  out  1  one-cycle pulse: request captured
cfg_done  out  1  one-cycle pulse: entered RUN
pll_pd  out  1  PLL power down
pll_mdec  out  17  registered feedback divider
pll_ndec  out  10  registered pre-divider
pll_pdec  out  7  registered post-divider
pll_mreq/pll_nreq/pll_preq  out  1 each  divider change requests
pll_directi/pll_directo/pll_bypass  out  1 each  registered mode bits
pll_clken  out  1  output clock enable
pll_lock  in  1  raw PLL lock (asynchronous, may be X while pd=1)
busy  out  1  state not IDLE/RUN/ERROR
locked  out  1  state == RUN
err_invalid  out  1  sticky: zero divider requested
err_timeout  out  1  sticky: retries exhausted
lock_lost  out  1  sticky: lock dropped in RUN
retry_cnt  out  2  attempts used in current request

Behaviour:
- Reset: state IDLE; pll_pd=1; dividers=1; all req/mode bits, clken, ack, done, flags, retry_cnt=0; lock synchronizer=0.
- pll_lock passes a 2-flop synchronizer (lock_s); lock_s forced 0 while pll_pd=1.
- Request accepted only in IDLE, RUN, ERROR when cfg_req=1. Sampled at edge T: cfg_ack=1 at T+1; clears err_*, lock_lost, retry_cnt.
- Any of cfg_m, cfg_n, cfg_p == 0: reject, err_invalid=1, go to IDLE with pll_pd=1, clken=0; PLL outputs otherwise unchanged.
- Valid request: at T+1 state PD_HOLD; pll_pd=1, clken=0, dividers/mode bits loaded, m/n/preq=1.
- PD_HOLD: count PD_CYCLES; pll_pd falls at T+1+PD_CYCLES; m/n/preq drop same edge; dividers never change while pd=0. If cfg_bypass=1: go directly to RUN, clken=1, cfg_done, no lock wait.
- WAIT_LOCK: timeout counter from 0; lock_s=1 -> STABLE. Counter reaches LOCK_TIMEOUT: retry_cnt+1; if retry_cnt < MAX_RETRY -> PD_HOLD (pd=1 again), else ERROR, err_timeout=1.
- STABLE: count consecutive lock_s=1; lock_s=0 -> WAIT_LOCK with timeout counter cleared; reaching LOCK_STABLE -> RUN; clken=1 and cfg_done pulse at that edge.
- RUN: locked=1. lock_s=0 -> clken=0 next edge, lock_lost=1, state WAIT_LOCK (AUTO_RELOCK=1) or ERROR (0). New request in RUN: clken=0 at T+1 simultaneously with pd=1.
- ERROR: pll_pd=1, clken=0; remains until a new request.
- Simultaneous request and lock drop in RUN: request wins; lock_lost still set.
- cfg_req held high: re-accepted each time state returns to IDLE/RUN/ERROR (level semantics; requester drops after ack).
- Async reset mid-sequence: immediate return to reset values, pd=1 asynchronously.

Decomposition:
Shared package pll_cfg_pkg: state enum (IDLE, PD_HOLD, WAIT_LOCK, STABLE, RUN, ERROR), divider width constants (17/10/7), config struct {m,n,p,directi,directo,bypass}. Sub-module pll_lock_sync (2-flop synchronizer with force-low input).

Test Plan:
- Nominal: m=20,n=2,p=1, lock rises 10 cycles after pd falls -> ack T+1, pd falls T+5, clken/cfg_done at lock+2+8 cycles, locked=1.
- Invalid: cfg_m=0 -> ack T+1, err_invalid=1, pd stays 1, clken 0, dividers unchanged.
- Timeout: lock never asserts -> 3 attempts of 64 cycles each with pd re-pulsed, retry_cnt=2, ERROR, err_timeout=1.
- Lock glitch: lock high 5 cycles, low 1, high -> STABLE restarts; clken only after 8 consecutive.
- Lock loss in RUN, AUTO_RELOCK=1 -> clken 0 next edge, lock_lost=1, relock returns to RUN without new request.
- Bypass: cfg_bypass=1 -> pd falls T+5, clken=1 same edge, no lock wait; reset asserted in PD_HOLD -> pd=1, clken 0 immediately.
